// File: rtl/cu_read_command_arbiter_pkg.sv
// Shared types and constants for the read command arbiter slice.
package cu_read_command_arbiter_pkg;

  localparam int NUM_READ_REQUESTERS   = 4;
  localparam int READ_ARB_QUEUE_DEPTH  = 8;
  localparam int READ_ARB_ALFULL_SLACK = 3;
  localparam int CU_ID_W               = 8;

  localparam logic [CU_ID_W-1:0] DATA_READ_CONTROL_ID   = 8'h10;
  localparam logic [CU_ID_W-1:0] INODE_READ_CONTROL_ID  = DATA_READ_CONTROL_ID + 8'd1;
  localparam logic [CU_ID_W-1:0] BLOCK_READ_CONTROL_ID  = DATA_READ_CONTROL_ID + 8'd2;
  localparam logic [CU_ID_W-1:0] VERTEX_READ_CONTROL_ID = DATA_READ_CONTROL_ID + 8'd3;

  typedef struct packed {
    logic [CU_ID_W-1:0] cu_id;
    logic [7:0]         tag;
  } CommandTagLine;

  typedef struct packed {
    logic          valid;
    CommandTagLine cmd;
    logic [63:0]   address;
    logic [11:0]   size;
  } CommandBufferLine;

  typedef struct packed {
    logic          valid;
    CommandTagLine cmd;
    logic [3:0]    response;
  } ResponseBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

  typedef struct packed {
    logic [NUM_READ_REQUESTERS-1:0] overflow;
    logic                           unrouted;
  } ReadArbStatus;

  function automatic BufferStatus queue_status(input int occ, input int depth, input int slack);
    BufferStatus s;
    s.alfull = (occ >= depth - slack);
    s.full   = (occ == depth);
    s.empty  = (occ == 0);
    return s;
  endfunction

endpackage

// File: rtl/cu_read_command_arbiter_if.sv
// Requester/downstream/response bundle of the read command arbiter.
interface cu_read_command_arbiter_if
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS   = NUM_READ_REQUESTERS,
  parameter int OUTSTANDING_BITS = 16
);
  logic                                              arbiter_enabled_in;
  CommandBufferLine  [NUM_REQUESTERS-1:0]            request_command_in;
  BufferStatus       [NUM_REQUESTERS-1:0]            request_buffer_status_out;
  BufferStatus                                       command_buffer_status;
  CommandBufferLine                                  command_out;
  ResponseBufferLine                                 response_in;
  ResponseBufferLine [NUM_REQUESTERS-1:0]            response_out;
  logic [NUM_REQUESTERS-1:0][OUTSTANDING_BITS-1:0]   outstanding_out;
  logic [NUM_REQUESTERS-1:0]                         overflow_error_out;
  logic                                              unrouted_error_out;

  modport slave (
    input  arbiter_enabled_in, request_command_in, command_buffer_status, response_in,
    output request_buffer_status_out, command_out, response_out, outstanding_out,
           overflow_error_out, unrouted_error_out
  );

  modport master (
    output arbiter_enabled_in, request_command_in, command_buffer_status, response_in,
    input  request_buffer_status_out, command_out, response_out, outstanding_out,
           overflow_error_out, unrouted_error_out
  );
endinterface

// File: rtl/cu_read_command_queue.sv
// Per-requester command FIFO; a pop frees the slot for a same-edge push even when full.
module cu_read_command_queue
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int DEPTH = READ_ARB_QUEUE_DEPTH,
  parameter int SLACK = READ_ARB_ALFULL_SLACK
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push_i,
  input  CommandBufferLine data_i,
  input  logic             pop_i,
  output CommandBufferLine head_o,
  output logic             nonempty_o,
  output BufferStatus      status_o,
  output logic             overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  CommandBufferLine mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      occ_q, occ_d;
  BufferStatus      status_q;
  logic             full, accept, pop;

  assign full   = (occ_q == FULL_OCC);
  assign pop    = pop_i && (occ_q != '0);
  assign accept = push_i && (!full || pop);

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + 1'b1;
    else if (!accept && pop) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_q     <= '0;
      wr_q     <= '0;
      occ_q    <= '0;
      status_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      occ_q    <= occ_d;
      status_q <= queue_status(int'(occ_d), DEPTH, SLACK);
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_q] <= data_i;
  end

  assign head_o     = mem_q[rd_q];
  assign nonempty_o = (occ_q != '0);
  assign status_o   = status_q;
  assign overflow_o = push_i && full && !pop;

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Round-robin read command arbiter: per-requester queues, one grant per cycle,
// response routing by cu_id and per-requester outstanding counters.
module cu_read_command_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int                 NUM_REQUESTERS   = NUM_READ_REQUESTERS,
  parameter int                 QUEUE_DEPTH      = READ_ARB_QUEUE_DEPTH,
  parameter int                 ALFULL_SLACK     = READ_ARB_ALFULL_SLACK,
  parameter logic [CU_ID_W-1:0] CU_ID_BASE       = DATA_READ_CONTROL_ID,
  parameter int                 OUTSTANDING_BITS = 16
) (
  input logic                      clock,
  input logic                      rstn,
  cu_read_command_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQUESTERS);

  logic                 enabled_q;
  logic [PW-1:0]        ptr_q;
  CommandBufferLine     grant_q, command_out_q;
  logic                 unrouted_q;

  CommandBufferLine  [NUM_REQUESTERS-1:0]                       head;
  BufferStatus       [NUM_REQUESTERS-1:0]                       status;
  ResponseBufferLine [NUM_REQUESTERS-1:0]                       resp_out;
  logic              [NUM_REQUESTERS-1:0][OUTSTANDING_BITS-1:0] outstanding;
  logic              [NUM_REQUESTERS-1:0]                       nonempty, push, pop, ovf_pulse, ovf;

  logic                 grant_vld;
  logic [PW-1:0]        grant_idx, cand;
  logic [CU_ID_W-1:0]   resp_off;
  logic                 resp_in_range, resp_hit;
  logic [PW-1:0]        resp_idx;
  logic                 unused_status;

  // Search starts one past the last winner so every requester is visited in turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (enabled_q && !bus.command_buffer_status.alfull) begin
      for (int k = 1; k <= NUM_REQUESTERS; k++) begin
        cand = PW'((int'(ptr_q) + k) % NUM_REQUESTERS);
        if (!grant_vld && nonempty[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign resp_off      = bus.response_in.cmd.cu_id - CU_ID_BASE;
  assign resp_in_range = (bus.response_in.cmd.cu_id >= CU_ID_BASE) && (int'(resp_off) < NUM_REQUESTERS);
  assign resp_hit      = bus.response_in.valid && resp_in_range;
  assign resp_idx      = resp_off[PW-1:0];
  assign unused_status = &{1'b0, bus.command_buffer_status.full, bus.command_buffer_status.empty};

  // A popped command waits in grant_q while disabled rather than being lost.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q     <= 1'b0;
      ptr_q         <= PW'(NUM_REQUESTERS - 1);
      grant_q       <= '0;
      command_out_q <= '0;
      unrouted_q    <= 1'b0;
    end else begin
      enabled_q <= bus.arbiter_enabled_in;
      if (enabled_q) begin
        command_out_q <= grant_q;
        grant_q       <= grant_vld ? head[grant_idx] : '0;
        if (grant_vld) ptr_q <= grant_idx;
      end else begin
        command_out_q <= '0;
      end
      if (bus.response_in.valid && !resp_in_range) unrouted_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : gen_lane
    logic [OUTSTANDING_BITS-1:0] cnt_q;
    logic                        ovf_q;
    ResponseBufferLine           resp_q;
    logic                        inc, dec;

    assign push[g] = enabled_q && bus.request_command_in[g].valid;
    assign pop[g]  = grant_vld && (grant_idx == PW'(g));
    assign inc     = pop[g];
    assign dec     = enabled_q && resp_hit && (resp_idx == PW'(g));

    cu_read_command_queue #(
      .DEPTH (QUEUE_DEPTH),
      .SLACK (ALFULL_SLACK)
    ) u_queue (
      .clock      (clock),
      .rstn       (rstn),
      .push_i     (push[g]),
      .data_i     (bus.request_command_in[g]),
      .pop_i      (pop[g]),
      .head_o     (head[g]),
      .nonempty_o (nonempty[g]),
      .status_o   (status[g]),
      .overflow_o (ovf_pulse[g])
    );

    always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        resp_q <= '0;
      end else begin
        if (inc && !dec && (cnt_q != '1))      cnt_q <= cnt_q + 1'b1;
        else if (dec && !inc && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
        if (ovf_pulse[g]) ovf_q <= 1'b1;
        resp_q <= (resp_hit && (resp_idx == PW'(g))) ? bus.response_in : '0;
      end
    end

    assign outstanding[g] = cnt_q;
    assign ovf[g]         = ovf_q;
    assign resp_out[g]    = resp_q;
  end

  assign bus.command_out               = command_out_q;
  assign bus.request_buffer_status_out = status;
  assign bus.response_out              = resp_out;
  assign bus.outstanding_out           = outstanding;
  assign bus.overflow_error_out        = ovf;
  assign bus.unrouted_error_out        = unrouted_q;

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Bench for cu_read_command_arbiter: directed scenarios plus random traffic
// against a queue-level reference model.
module tb_cu_read_command_arbiter;
  import cu_read_command_arbiter_pkg::*;

  localparam int NR   = 4;
  localparam int QD   = 8;
  localparam int SL   = 3;
  localparam int OB   = 16;
  localparam int CMAX = (1 << OB) - 1;
  localparam logic [7:0] BASE = DATA_READ_CONTROL_ID;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  always #5 clock = ~clock;

  cu_read_command_arbiter_if #(.NUM_REQUESTERS(NR), .OUTSTANDING_BITS(OB)) bus ();

  cu_read_command_arbiter #(
    .NUM_REQUESTERS   (NR),
    .QUEUE_DEPTH      (QD),
    .ALFULL_SLACK     (SL),
    .CU_ID_BASE       (BASE),
    .OUTSTANDING_BITS (OB)
  ) dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  CommandBufferLine  mq [NR][$];
  CommandBufferLine  m_stage, m_cmd;
  ResponseBufferLine m_resp [NR];
  BufferStatus       m_st [NR];
  int                m_cnt [NR];
  bit                m_ovf [NR];
  bit                m_unr, m_en;
  int                m_ptr;

  int nv, first, last;
  logic [7:0] order [$];
  ResponseBufferLine r;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic CommandBufferLine mk_cmd(input int i);
    CommandBufferLine c;
    c.valid     = 1'b1;
    c.cmd.cu_id = BASE + 8'(i);
    c.cmd.tag   = 8'($urandom);
    c.address   = {$urandom, $urandom};
    c.size      = 12'($urandom);
    return c;
  endfunction

  function automatic ResponseBufferLine mk_resp(input logic [7:0] id);
    ResponseBufferLine x;
    x.valid     = 1'b1;
    x.cmd.cu_id = id;
    x.cmd.tag   = 8'($urandom);
    x.response  = 4'($urandom);
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mq[i].delete();
      m_resp[i] = '0;
      m_st[i]   = '0;
      m_cnt[i]  = 0;
      m_ovf[i]  = 1'b0;
    end
    m_stage = '0;
    m_cmd   = '0;
    m_unr   = 1'b0;
    m_en    = 1'b0;
    m_ptr   = NR - 1;
  endtask

  // One clock edge of the specified behaviour, from the inputs held across it.
  task automatic model_step();
    int win, off, sz;
    int pre [NR];
    bit en, hit, inc, dec;
    en  = m_en;
    win = -1;
    for (int i = 0; i < NR; i++) pre[i] = mq[i].size();
    if (en && !bus.command_buffer_status.alfull)
      for (int k = 1; k <= NR; k++)
        if (win < 0 && pre[(m_ptr + k) % NR] > 0) win = (m_ptr + k) % NR;
    if (en) begin
      m_cmd   = m_stage;
      m_stage = '0;
      if (win >= 0) begin
        m_stage = mq[win].pop_front();
        m_ptr   = win;
      end
    end else begin
      m_cmd = '0;
    end
    for (int i = 0; i < NR; i++)
      if (en && bus.request_command_in[i].valid) begin
        if (pre[i] < QD || win == i) mq[i].push_back(bus.request_command_in[i]);
        else m_ovf[i] = 1'b1;
      end
    off = int'(bus.response_in.cmd.cu_id) - int'(BASE);
    hit = bus.response_in.valid && off >= 0 && off < NR;
    if (bus.response_in.valid && !hit) m_unr = 1'b1;
    for (int i = 0; i < NR; i++) begin
      m_resp[i] = (hit && off == i) ? bus.response_in : '0;
      inc = (win == i);
      dec = en && hit && off == i;
      if (inc && !dec && m_cnt[i] < CMAX) m_cnt[i]++;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      sz = mq[i].size();
      m_st[i].alfull = (sz >= QD - SL);
      m_st[i].full   = (sz == QD);
      m_st[i].empty  = (sz == 0);
    end
    m_en = bus.arbiter_enabled_in;
  endtask

  task automatic compare_all();
    chk("command_out", 128'(bus.command_out), 128'(m_cmd));
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("response_out[%0d]", i), 128'(bus.response_out[i]), 128'(m_resp[i]));
      chk($sformatf("outstanding[%0d]", i), 128'(bus.outstanding_out[i]), 128'(m_cnt[i]));
      chk($sformatf("status[%0d]", i), 128'(bus.request_buffer_status_out[i]), 128'(m_st[i]));
      chk($sformatf("overflow[%0d]", i), 128'(bus.overflow_error_out[i]), 128'(m_ovf[i]));
    end
    chk("unrouted", 128'(bus.unrouted_error_out), 128'(m_unr));
  endtask

  task automatic cycle();
    @(posedge clock);
    if (rstn) model_step();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.request_command_in = '0;
    bus.response_in        = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    bus.arbiter_enabled_in    = 1'b0;
    bus.command_buffer_status = '0;
    #2;
    model_reset();
    compare_all();
    cycle();
    rstn = 1'b1;
  endtask

  initial begin
    idle();
    bus.arbiter_enabled_in    = 1'b0;
    bus.command_buffer_status = '0;

    // single requester burst
    do_reset();
    bus.arbiter_enabled_in = 1'b1;
    cycle();
    nv = 0; first = -1; last = -1;
    for (int k = 0; k < 9; k++) begin
      idle();
      if (k < 3) bus.request_command_in[0] = mk_cmd(0);
      cycle();
      if (bus.command_out.valid) begin
        nv++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("a_count", 128'(nv), 128'(3));
    chk("a_first", 128'(first), 128'(2));
    chk("a_last", 128'(last), 128'(4));
    chk("a_outst0", 128'(bus.outstanding_out[0]), 128'(3));

    // fairness from reset: two entries per queue
    do_reset();
    bus.arbiter_enabled_in = 1'b1;
    cycle();
    bus.command_buffer_status.alfull = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) bus.request_command_in[i] = mk_cmd(i);
      cycle();
    end
    idle();
    bus.command_buffer_status.alfull = 1'b0;
    order.delete();
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (bus.command_out.valid) order.push_back(bus.command_out.cmd.cu_id);
    end
    chk("b_grants", 128'(order.size()), 128'(8));
    for (int k = 0; k < 8; k++)
      if (k < order.size()) chk($sformatf("b_order%0d", k), 128'(order[k]), 128'(BASE + 8'(k % NR)));

    // backpressure for 10 cycles, then resume
    bus.command_buffer_status.alfull = 1'b1;
    bus.request_command_in[1] = mk_cmd(1);
    bus.request_command_in[3] = mk_cmd(3);
    cycle();
    idle();
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (bus.command_out.valid) nv++;
    end
    chk("c_blocked", 128'(nv), 128'(0));
    bus.command_buffer_status.alfull = 1'b0;
    cycle();
    cycle();
    chk("c_resume_vld", 128'(bus.command_out.valid), 128'(1));
    chk("c_resume_id", 128'(bus.command_out.cmd.cu_id), 128'(BASE + 8'd1));
    for (int k = 0; k < 4; k++) cycle();

    // queue limits on requester 1 with downstream blocked
    bus.command_buffer_status.alfull = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      idle();
      bus.request_command_in[1] = mk_cmd(1);
      cycle();
      chk($sformatf("d_alfull%0d", k), 128'(bus.request_buffer_status_out[1].alfull), 128'(k >= 5));
      chk($sformatf("d_full%0d", k), 128'(bus.request_buffer_status_out[1].full), 128'(k >= 8));
      chk($sformatf("d_ovf%0d", k), 128'(bus.overflow_error_out[1]), 128'(k == 9));
    end
    idle();
    bus.command_buffer_status.alfull = 1'b0;
    for (int k = 0; k < 12; k++) cycle();

    // routing on the same edge as a grant, then an unowned cu_id
    do_reset();
    bus.arbiter_enabled_in = 1'b1;
    cycle();
    bus.request_command_in[2] = mk_cmd(2);
    cycle();
    idle();
    r = mk_resp(BASE + 8'd2);
    bus.response_in = r;
    cycle();
    chk("e_resp2", 128'(bus.response_out[2]), 128'(r));
    chk("e_resp0", 128'(bus.response_out[0]), 128'(0));
    chk("e_outst2", 128'(bus.outstanding_out[2]), 128'(0));
    idle();
    bus.response_in = mk_resp(BASE + 8'd9);
    cycle();
    chk("e_unrouted", 128'(bus.unrouted_error_out), 128'(1));
    chk("e_dropped", 128'(bus.response_out[2]), 128'(0));
    idle();
    cycle();

    // asynchronous reset with queues loaded
    bus.command_buffer_status.alfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NR; i++) bus.request_command_in[i] = mk_cmd(i);
      cycle();
    end
    idle();
    rstn = 1'b0;
    #2;
    model_reset();
    compare_all();
    chk("f_async_cmd", 128'(bus.command_out), 128'(0));
    cycle();
    rstn = 1'b1;
    bus.command_buffer_status.alfull = 1'b0;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (bus.command_out.valid) nv++;
    end
    chk("f_no_stale", 128'(nv), 128'(0));

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) do_reset();
      bus.arbiter_enabled_in           = ($urandom_range(0, 49) != 0);
      bus.command_buffer_status.alfull = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++)
        bus.request_command_in[i] = ($urandom_range(0, 99) < 35) ? mk_cmd(i) : '0;
      if ($urandom_range(0, 99) < 40)
        bus.response_in = mk_resp(($urandom_range(0, 9) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, NR - 1)));
      else
        bus.response_in = '0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
